// File: rtl/slowcontrol_frame_decoder.sv
// Backplane slow-control frame decoder.
// Pairs tagged high bytes with the following untagged low byte to form 16-bit
// words, runs an IDLE/FRAME protocol FSM over fst/nxt/lst words, and drives
// setting registers, stretched command pulses and a test-data stream port.
// Frame errors (stray nxt/lst, fst inside a frame, unknown opcode, inter-word
// timeout) are tallied in a saturating counter.
module slowcontrol_frame_decoder #(
  parameter int NREG       = 8,
  parameter int REGW       = 8,
  parameter int REG_BASE   = 1,
  parameter int NPULSE     = 10,
  parameter int PULSE_BASE = 20,
  parameter int PULSE_LEN  = 1,
  parameter int STREAM_OP  = 10,
  parameter int TIMEOUT    = 255
) (
  input  logic                 clk16,
  input  logic                 reset,
  input  logic [9:0]           bytin,
  input  logic                 err_clr,
  output logic [NREG*REGW-1:0] regs_out,
  output logic [NPULSE-1:0]    pulses,
  output logic                 fsto,
  output logic                 davo,
  output logic                 lsto,
  output logic [15:0]          dato,
  output logic                 stream_abort,
  output logic                 frame_active,
  output logic [7:0]           last_op,
  output logic [7:0]           err_count
);

  localparam int PCW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
  localparam int TCW = $clog2(TIMEOUT + 1);
  localparam logic [8:0]     REG_LO       = 9'(REG_BASE);
  localparam logic [8:0]     REG_HI       = 9'(REG_BASE + NREG);
  localparam logic [8:0]     PUL_LO       = 9'(PULSE_BASE);
  localparam logic [8:0]     PUL_HI       = 9'(PULSE_BASE + NPULSE);
  localparam logic [7:0]     STREAM_CODE  = 8'(STREAM_OP);
  localparam logic [TCW-1:0] IDLE_MAX     = TCW'(TIMEOUT);
  localparam logic [PCW-1:0] PULSE_RELOAD = PCW'(PULSE_LEN - 1);
  localparam logic [1:0]     TAG_FST      = 2'd1;
  localparam logic [1:0]     TAG_NXT      = 2'd2;
  localparam logic [1:0]     TAG_LST      = 2'd3;

  typedef enum logic {S_IDLE = 1'b0, S_FRAME = 1'b1} state_t;

  logic [9:0]                lsbyt_r, msbyt_r;
  state_t                    state_r, state_s;
  logic [7:0]                op_r, op_s, last_op_r, last_op_s;
  logic                      first_r, first_s;
  logic [TCW-1:0]            idle_cnt_r, idle_cnt_s;
  logic [NREG-1:0][REGW-1:0] regs_r;
  logic [PCW-1:0]            pulse_cnt_r [NPULSE];
  logic [NPULSE-1:0]         pulses_r;
  logic                      fsto_r, davo_r, lsto_r, abort_r;
  logic [15:0]               dato_r;
  logic [7:0]                err_count_r, err_count_s;

  logic                      word_ev_s, is_stream_s, reg_hit_s, pulse_hit_s;
  logic [1:0]                tag_s;
  logic [15:0]               word_s;
  logic [8:0]                reg_idx_s, pulse_idx_s;
  logic                      fsto_s, davo_s, lsto_s, abort_s, err_s, reg_we_s, pulse_trig_s;
  logic [15:0]               dato_s;

  // Word detection and opcode range decode of the currently open frame.
  always_comb begin
    tag_s       = msbyt_r[9:8];
    word_s      = {msbyt_r[7:0], lsbyt_r[7:0]};
    word_ev_s   = (msbyt_r[9:8] != 2'd0) && (lsbyt_r[9:8] == 2'd0);
    is_stream_s = (op_r == STREAM_CODE);
    reg_hit_s   = ({1'b0, op_r} >= REG_LO) && ({1'b0, op_r} < REG_HI);
    pulse_hit_s = ({1'b0, op_r} >= PUL_LO) && ({1'b0, op_r} < PUL_HI);
    reg_idx_s   = {1'b0, op_r} - REG_LO;
    pulse_idx_s = {1'b0, op_r} - PUL_LO;
  end

  // Protocol FSM: next state, frame bookkeeping and per-word actions.
  always_comb begin
    state_s      = state_r;
    op_s         = op_r;
    last_op_s    = last_op_r;
    first_s      = first_r;
    idle_cnt_s   = idle_cnt_r;
    fsto_s       = 1'b0;
    davo_s       = 1'b0;
    lsto_s       = 1'b0;
    dato_s       = 16'h0000;
    abort_s      = 1'b0;
    err_s        = 1'b0;
    reg_we_s     = 1'b0;
    pulse_trig_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        idle_cnt_s = '0;
        if (word_ev_s) begin
          if (tag_s == TAG_FST) begin
            op_s      = word_s[7:0];
            last_op_s = word_s[7:0];
            first_s   = 1'b1;
            state_s   = S_FRAME;
          end else begin
            err_s = 1'b1;
          end
        end else begin
          err_s = 1'b0;
        end
      end
      S_FRAME: begin
        if (word_ev_s) begin
          idle_cnt_s = '0;
          case (tag_s)
            TAG_FST: begin
              // restart the frame; an open stream is cut short
              err_s     = 1'b1;
              abort_s   = is_stream_s;
              op_s      = word_s[7:0];
              last_op_s = word_s[7:0];
              first_s   = 1'b1;
            end
            TAG_NXT: begin
              if (is_stream_s) begin
                davo_s  = 1'b1;
                dato_s  = word_s;
                fsto_s  = first_r;
                first_s = 1'b0;
              end else begin
                davo_s = 1'b0;
              end
            end
            TAG_LST: begin
              state_s = S_IDLE;
              if (is_stream_s) begin
                davo_s  = 1'b1;
                dato_s  = word_s;
                fsto_s  = first_r;
                lsto_s  = 1'b1;
                first_s = 1'b0;
              end else if (reg_hit_s) begin
                reg_we_s = 1'b1;
              end else if (pulse_hit_s) begin
                pulse_trig_s = 1'b1;
              end else begin
                err_s = 1'b1;
              end
            end
            default: begin
              state_s = S_FRAME;
            end
          endcase
        end else if (idle_cnt_r == IDLE_MAX) begin
          err_s      = 1'b1;
          abort_s    = is_stream_s;
          state_s    = S_IDLE;
          idle_cnt_s = '0;
        end else begin
          idle_cnt_s = idle_cnt_r + TCW'(1);
        end
      end
      default: begin
        state_s    = S_IDLE;
        idle_cnt_s = '0;
      end
    endcase
  end

  // Error counter update: clear wins over accumulation, saturates at 255.
  always_comb begin
    err_count_s = err_count_r;
    if (err_clr) begin
      err_count_s = err_s ? 8'd1 : 8'd0;
    end else if (err_s && (err_count_r != 8'hFF)) begin
      err_count_s = err_count_r + 8'd1;
    end else begin
      err_count_s = err_count_r;
    end
  end

  // Byte pipeline, FSM state and registered stream/status outputs.
  always_ff @(posedge clk16) begin
    if (reset) begin
      lsbyt_r     <= 10'd0;
      msbyt_r     <= 10'd0;
      state_r     <= S_IDLE;
      op_r        <= 8'd0;
      last_op_r   <= 8'd0;
      first_r     <= 1'b0;
      idle_cnt_r  <= '0;
      fsto_r      <= 1'b0;
      davo_r      <= 1'b0;
      lsto_r      <= 1'b0;
      dato_r      <= 16'h0000;
      abort_r     <= 1'b0;
      err_count_r <= 8'd0;
    end else begin
      lsbyt_r     <= bytin;
      msbyt_r     <= lsbyt_r;
      state_r     <= state_s;
      op_r        <= op_s;
      last_op_r   <= last_op_s;
      first_r     <= first_s;
      idle_cnt_r  <= idle_cnt_s;
      fsto_r      <= fsto_s;
      davo_r      <= davo_s;
      lsto_r      <= lsto_s;
      dato_r      <= dato_s;
      abort_r     <= abort_s;
      err_count_r <= err_count_s;
    end
  end

  // Setting register bank: only the addressed register loads on lst.
  always_ff @(posedge clk16) begin
    for (int i = 0; i < NREG; i++) begin
      if (reset) begin
        regs_r[i] <= '0;
      end else if (reg_we_s && (reg_idx_s == 9'(i))) begin
        regs_r[i] <= word_s[REGW-1:0];
      end
    end
  end

  // Pulse stretchers: a trigger (re)loads the remaining-cycle count.
  always_ff @(posedge clk16) begin
    for (int j = 0; j < NPULSE; j++) begin
      if (reset) begin
        pulse_cnt_r[j] <= '0;
        pulses_r[j]    <= 1'b0;
      end else if (pulse_trig_s && (pulse_idx_s == 9'(j))) begin
        pulse_cnt_r[j] <= PULSE_RELOAD;
        pulses_r[j]    <= 1'b1;
      end else if (pulse_cnt_r[j] != '0) begin
        pulse_cnt_r[j] <= pulse_cnt_r[j] - PCW'(1);
        pulses_r[j]    <= 1'b1;
      end else begin
        pulses_r[j] <= 1'b0;
      end
    end
  end

  assign regs_out     = regs_r;
  assign pulses       = pulses_r;
  assign fsto         = fsto_r;
  assign davo         = davo_r;
  assign lsto         = lsto_r;
  assign dato         = dato_r;
  assign stream_abort = abort_r;
  assign frame_active = (state_r == S_FRAME);
  assign last_op      = last_op_r;
  assign err_count    = err_count_r;

endmodule

// File: tb/tb_slowcontrol_frame_decoder.sv
// Self-checking bench for slowcontrol_frame_decoder: directed scenarios with
// literal expectations plus randomized byte streams, all compared every cycle
// against a byte-level reference model of the frame protocol.
module tb_slowcontrol_frame_decoder;

  localparam int NREG       = 8;
  localparam int REGW       = 8;
  localparam int REG_BASE   = 1;
  localparam int NPULSE     = 10;
  localparam int PULSE_BASE = 20;
  // long enough that a back-to-back frame lands while the pulse is still high
  localparam int PULSE_LEN  = 5;
  localparam int STREAM_OP  = 10;
  localparam int TIMEOUT    = 255;

  logic                 clk16 = 1'b0;
  logic                 reset = 1'b1;
  logic [9:0]           bytin = 10'd0;
  logic                 err_clr = 1'b0;
  logic [NREG*REGW-1:0] regs_out;
  logic [NPULSE-1:0]    pulses;
  logic                 fsto, davo, lsto, stream_abort, frame_active;
  logic [15:0]          dato;
  logic [7:0]           last_op, err_count;

  int n_tests = 0;
  int n_fail  = 0;

  slowcontrol_frame_decoder #(
    .NREG(NREG), .REGW(REGW), .REG_BASE(REG_BASE), .NPULSE(NPULSE),
    .PULSE_BASE(PULSE_BASE), .PULSE_LEN(PULSE_LEN), .STREAM_OP(STREAM_OP),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk16(clk16), .reset(reset), .bytin(bytin), .err_clr(err_clr),
    .regs_out(regs_out), .pulses(pulses), .fsto(fsto), .davo(davo),
    .lsto(lsto), .dato(dato), .stream_abort(stream_abort),
    .frame_active(frame_active), .last_op(last_op), .err_count(err_count)
  );

  always #5 clk16 = ~clk16;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (byte-stream level) ----------------
  logic [9:0]  p_ms, p_ls;
  bit          m_valid = 1'b0;
  bit          m_open, m_nodata, ev, err;
  int          m_op, m_idle, m_err, tag;
  int          m_regs [NREG];
  int          m_rem  [NPULSE];
  logic [15:0] w;
  logic        e_fsto, e_davo, e_lsto, e_abort;
  logic [15:0] e_dato;
  logic [7:0]  e_last_op;

  always @(posedge clk16) begin
    if (reset) begin
      p_ms = 10'd0; p_ls = 10'd0; m_open = 0; m_nodata = 0; m_op = 0; m_idle = 0; m_err = 0;
      e_fsto = 0; e_davo = 0; e_lsto = 0; e_abort = 0; e_dato = 16'h0; e_last_op = 8'h0;
      for (int i = 0; i < NREG; i++) m_regs[i] = 0;
      for (int j = 0; j < NPULSE; j++) m_rem[j] = 0;
      m_valid = 1'b1;
    end else begin
      ev  = (p_ms[9:8] != 2'd0) && (p_ls[9:8] == 2'd0);
      tag = int'(p_ms[9:8]);
      w   = {p_ms[7:0], p_ls[7:0]};
      e_fsto = 0; e_davo = 0; e_lsto = 0; e_abort = 0; e_dato = 16'h0; err = 0;
      for (int j = 0; j < NPULSE; j++) if (m_rem[j] > 0) m_rem[j]--;
      if (ev) begin
        m_idle = 0;
        if (!m_open) begin
          if (tag == 1) begin
            m_op = int'(w[7:0]); e_last_op = w[7:0]; m_open = 1; m_nodata = 1;
          end else err = 1;
        end else if (tag == 1) begin
          err = 1;
          if (m_op == STREAM_OP) e_abort = 1;
          m_op = int'(w[7:0]); e_last_op = w[7:0]; m_nodata = 1;
        end else begin
          if (m_op == STREAM_OP) begin
            e_davo = 1; e_dato = w; e_fsto = m_nodata; m_nodata = 0; e_lsto = (tag == 3);
          end
          if (tag == 3) begin
            m_open = 0;
            if (m_op == STREAM_OP) err = 0;
            else if (m_op >= REG_BASE && m_op < REG_BASE + NREG)
              m_regs[m_op - REG_BASE] = int'(w) % (1 << REGW);
            else if (m_op >= PULSE_BASE && m_op < PULSE_BASE + NPULSE)
              m_rem[m_op - PULSE_BASE] = PULSE_LEN;
            else err = 1;
          end
        end
      end else if (m_open) begin
        m_idle++;
        if (m_idle > TIMEOUT) begin
          err = 1; m_open = 0; m_idle = 0; e_abort = (m_op == STREAM_OP);
        end
      end
      if (err_clr) m_err = err ? 1 : 0;
      else if (err && m_err < 255) m_err++;
      p_ms = p_ls;
      p_ls = bytin;
    end
  end

  // ---------------- every-cycle comparison against the model ----------------
  logic [NREG*REGW-1:0] exp_regs;
  logic [NPULSE-1:0]    exp_pulses;

  always @(negedge clk16) begin
    if (m_valid) begin
      for (int i = 0; i < NREG; i++) exp_regs[i*REGW +: REGW] = REGW'(m_regs[i]);
      for (int j = 0; j < NPULSE; j++) exp_pulses[j] = (m_rem[j] > 0);
      chk("regs_out", regs_out, exp_regs);
      chk("pulses", pulses, exp_pulses);
      chk("fsto", fsto, e_fsto);
      chk("davo", davo, e_davo);
      chk("lsto", lsto, e_lsto);
      chk("dato", dato, e_dato);
      chk("stream_abort", stream_abort, e_abort);
      chk("frame_active", frame_active, m_open);
      chk("last_op", last_op, e_last_op);
      chk("err_count", err_count, 8'(m_err));
    end
  end

  // ---------------- observation counters for literal checks ----------------
  int          p2_cnt = 0, p2_rise = 0, davo_cnt = 0, fsto_cnt = 0, lsto_cnt = 0, abort_cnt = 0;
  logic        p2_prev = 1'b0;
  logic [15:0] fsto_dat, lsto_dat;
  logic [15:0] dq [$];

  always @(negedge clk16) begin
    if (pulses[2] === 1'b1) p2_cnt++;
    if (pulses[2] === 1'b1 && p2_prev !== 1'b1) p2_rise++;
    p2_prev = pulses[2];
    if (davo === 1'b1) begin davo_cnt++; dq.push_back(dato); end
    if (fsto === 1'b1) begin fsto_cnt++; fsto_dat = dato; end
    if (lsto === 1'b1) begin lsto_cnt++; lsto_dat = dato; end
    if (stream_abort === 1'b1) abort_cnt++;
  end

  task automatic clear_obs();
    p2_cnt = 0; p2_rise = 0; davo_cnt = 0; fsto_cnt = 0; lsto_cnt = 0; abort_cnt = 0;
    fsto_dat = 16'h0; lsto_dat = 16'h0; dq.delete();
  endtask

  // ---------------- stimulus helpers (drive on falling edge) ----------------
  task automatic put(input logic [1:0] t, input logic [7:0] d);
    @(negedge clk16);
    bytin = {t, d};
  endtask

  task automatic send_word(input logic [1:0] t, input logic [15:0] wd);
    put(t, wd[15:8]);
    put(2'd0, wd[7:0]);
  endtask

  task automatic idle(input int n);
    repeat (n) put(2'd0, 8'h00);
  endtask

  function automatic logic [7:0] pick_op();
    case ($urandom_range(0, 5))
      0:       return 8'($urandom_range(1, 8));
      1, 4:    return 8'(STREAM_OP);
      2:       return 8'($urandom_range(20, 29));
      3:       return 8'($urandom_range(0, 255));
      default: return 8'($urandom_range(0, 31));
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    logic [1:0]  rt;
    logic [15:0] rw;
    int          r;

    // reset state
    repeat (3) @(negedge clk16);
    chk("reset regs_out", regs_out, 64'h0);
    chk("reset err_count", err_count, 8'h00);
    chk("reset frame_active", frame_active, 1'b0);
    chk("reset last_op", last_op, 8'h00);
    reset = 1'b0;
    idle(3);

    // 1: register write, op 3 -> register 2
    send_word(2'd1, 16'h0003);
    send_word(2'd3, 16'h00A5);
    idle(2);
    chk("t1 regs_out", regs_out, 64'h0000_0000_00A5_0000);
    chk("t1 err_count", err_count, 8'h00);
    chk("t1 last_op", last_op, 8'h03);

    // 2: pulse op 22 -> pulses[2], then retrigger while high
    clear_obs();
    send_word(2'd1, 16'h0016);
    send_word(2'd3, 16'h0000);
    idle(12);
    chk("t2 pulse width", 32'(p2_cnt), 32'd5);
    chk("t2 pulse rises", 32'(p2_rise), 32'd1);
    clear_obs();
    send_word(2'd1, 16'h0016);
    send_word(2'd3, 16'h0000);
    send_word(2'd1, 16'h0016);
    send_word(2'd3, 16'h0000);
    idle(15);
    chk("t2 retrigger width", 32'(p2_cnt), 32'd9);
    chk("t2 retrigger rises", 32'(p2_rise), 32'd1);

    // 3: stream frame
    clear_obs();
    send_word(2'd1, 16'h000A);
    send_word(2'd2, 16'h1234);
    send_word(2'd2, 16'h5678);
    send_word(2'd3, 16'h9ABC);
    idle(3);
    chk("t3 davo count", 32'(davo_cnt), 32'd3);
    chk("t3 fsto count", 32'(fsto_cnt), 32'd1);
    chk("t3 lsto count", 32'(lsto_cnt), 32'd1);
    chk("t3 fsto data", fsto_dat, 16'h1234);
    chk("t3 lsto data", lsto_dat, 16'h9ABC);
    chk("t3 data words", {dq.size() > 0 ? dq[0] : 16'hxxxx, dq.size() > 1 ? dq[1] : 16'hxxxx,
                          dq.size() > 2 ? dq[2] : 16'hxxxx}, 48'h1234_5678_9ABC);

    // 4: malformed frames, then clear together with a fourth error
    send_word(2'd3, 16'h0000);
    send_word(2'd1, 16'h0005);
    send_word(2'd1, 16'h0063);
    send_word(2'd3, 16'h0000);
    idle(2);
    chk("t4 err_count", err_count, 8'd3);
    send_word(2'd3, 16'h0000);
    @(negedge clk16);
    err_clr = 1'b1;
    bytin   = 10'd0;
    @(negedge clk16);
    err_clr = 1'b0;
    chk("t4 err_clr+error", err_count, 8'd1);

    // 5: stream timeout
    @(negedge clk16);
    err_clr = 1'b1;
    @(negedge clk16);
    err_clr = 1'b0;
    clear_obs();
    send_word(2'd1, 16'h000A);
    send_word(2'd2, 16'h1111);
    idle(300);
    chk("t5 abort count", 32'(abort_cnt), 32'd1);
    chk("t5 lsto count", 32'(lsto_cnt), 32'd0);
    chk("t5 frame_active", frame_active, 1'b0);
    chk("t5 err_count", err_count, 8'd1);

    // 6: reset in the middle of a stream frame
    clear_obs();
    send_word(2'd1, 16'h000A);
    send_word(2'd2, 16'h2222);
    @(negedge clk16);
    reset = 1'b1;
    bytin = 10'd0;
    @(negedge clk16);
    chk("t6 reset outputs", {regs_out, pulses, fsto, davo, lsto, dato, stream_abort,
                             frame_active, last_op, err_count}, 128'h0);
    @(negedge clk16);
    reset = 1'b0;
    send_word(2'd3, 16'h0000);
    idle(2);
    chk("t6 lst after reset err", err_count, 8'd1);
    chk("t6 no stream data", 32'(davo_cnt), 32'd0);

    // randomized traffic
    for (int it = 0; it < 800; it++) begin
      err_clr = ($urandom_range(0, 19) == 0);
      r = $urandom_range(0, 19);
      if (r <= 10) begin
        r  = $urandom_range(0, 99);
        rt = (r < 35) ? 2'd1 : (r < 70) ? 2'd2 : 2'd3;
        rw = 16'($urandom_range(0, 65535));
        if (rt == 2'd1) rw[7:0] = pick_op();
        send_word(rt, rw);
      end else if (r <= 13) begin
        put(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
      end else if (r <= 16) begin
        idle($urandom_range(0, 4));
      end else if (r == 17) begin
        err_clr = 1'b0;
        idle($urandom_range(250, 262));
      end else if (r == 18) begin
        put(2'($urandom_range(1, 3)), 8'($urandom_range(0, 255)));
        put(2'($urandom_range(1, 3)), 8'($urandom_range(0, 255)));
      end else if ($urandom_range(0, 4) == 0) begin
        @(negedge clk16);
        reset = 1'b1;
        idle($urandom_range(0, 2));
        @(negedge clk16);
        reset = 1'b0;
      end else begin
        idle(1);
      end
    end
    err_clr = 1'b0;
    idle(5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
